// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter for a single register file write port
// Grants one of ALU/load/debug per cycle and registers the winner onto the write port.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 hold,
    output logic                 rf_wr_en,
    output logic [AW-1:0]        rf_wr_addr,
    output logic [DW-1:0]        rf_wrdata,
    output logic [31:0]          pending,
    output logic [15:0]          wr_count
);

    logic [1:0]      r_rr_ptr;
    logic            r_wr_en;
    logic [AW-1:0]   r_wr_addr;
    logic [DW-1:0]   r_wrdata;
    logic [31:0]     r_pending;
    logic [15:0]     r_wr_count;

    logic [1:0]      w_ord [3];
    logic [1:0]      w_win;
    logic            w_any;
    logic [NREQ-1:0] w_grant;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_data;

    // Search starts just after the last winner; pointer value 3 never occurs but maps like 2.
    always_comb begin
        case (r_rr_ptr)
            2'd0: begin
                w_ord[0] = 2'd1; w_ord[1] = 2'd2; w_ord[2] = 2'd0;
            end
            2'd1: begin
                w_ord[0] = 2'd2; w_ord[1] = 2'd0; w_ord[2] = 2'd1;
            end
            default: begin
                w_ord[0] = 2'd0; w_ord[1] = 2'd1; w_ord[2] = 2'd2;
            end
        endcase
    end

    always_comb begin
        w_grant = '0;
        w_any   = 1'b0;
        w_win   = 2'd0;
        if (nrst && !hold) begin
            for (int k = 0; k < 3; k++) begin
                if (!w_any && req_valid[w_ord[k]]) begin
                    w_any = 1'b1;
                    w_win = w_ord[k];
                end
            end
        end
        if (w_any) begin
            w_grant[w_win] = 1'b1;
        end
    end

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = req_addr[i*AW +: AW];
                w_sel_data = req_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rr_ptr   <= 2'd2;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wrdata   <= '0;
            r_pending  <= '0;
            r_wr_count <= '0;
        end else begin
            if (w_any) begin
                r_rr_ptr  <= w_win;
                r_wr_addr <= w_sel_addr;
                r_wrdata  <= w_sel_data;
                // x0 writes complete the handshake but never reach the register file
                r_wr_en   <= (w_sel_addr != '0);
                r_pending <= (w_sel_addr != '0) ? (32'd1 << w_sel_addr) : 32'd0;
            end else begin
                r_wr_en   <= 1'b0;
                r_pending <= '0;
            end
            if (r_wr_en) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

    assign req_ready  = w_grant;
    assign rf_wr_en   = r_wr_en;
    assign rf_wr_addr = r_wr_addr;
    assign rf_wrdata  = r_wrdata;
    assign pending    = r_pending;
    assign wr_count   = r_wr_count;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - vector table and directed corner sequences for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic         clk = 1'b0;
    logic         nrst;
    logic [2:0]   req_valid;
    logic [14:0]  req_addr;
    logic [95:0]  req_data;
    logic [2:0]   req_ready;
    logic         hold;
    logic         rf_wr_en;
    logic [4:0]   rf_wr_addr;
    logic [31:0]  rf_wrdata;
    logic [31:0]  pending;
    logic [15:0]  wr_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] rf_model [32];

    regfile_wb_arbiter #(.NREQ(3), .AW(5), .DW(32)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .hold       (hold),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wrdata  (rf_wrdata),
        .pending    (pending),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_wr_en) rf_model[rf_wr_addr] <= rf_wrdata;
    end

    typedef struct {
        logic        hold;
        logic [2:0]  v;
        logic [14:0] a;
        logic [95:0] d;
        logic [2:0]  ready;
        logic        en;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] pend;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nrst      = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        hold      = 1'b0;
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
    endtask

    localparam logic [14:0] A123 = {5'd3, 5'd2, 5'd1};
    localparam logic [95:0] D123 = {32'hA3, 32'hA2, 32'hA1};

    initial begin
        for (int r = 0; r < 32; r++) rf_model[r] = '0;

        tbl[0]  = '{1'b0, 3'b000, 15'd0, 96'd0, 3'b000, 1'b0, 5'd0, 32'h0, 32'h0, 16'd0};
        tbl[1]  = '{1'b0, 3'b010, {5'd0, 5'd7, 5'd0}, {32'd0, 32'hDEADBEEF, 32'd0},
                    3'b000 | 3'b010, 1'b0, 5'd0, 32'h0, 32'h0, 16'd0};
        tbl[2]  = '{1'b0, 3'b000, 15'd0, 96'd0, 3'b000, 1'b1, 5'd7, 32'hDEADBEEF, 32'h80, 16'd0};
        tbl[3]  = '{1'b0, 3'b111, A123, D123, 3'b100, 1'b0, 5'd7, 32'hDEADBEEF, 32'h0, 16'd1};
        tbl[4]  = '{1'b0, 3'b111, A123, D123, 3'b001, 1'b1, 5'd3, 32'hA3, 32'h8, 16'd1};
        tbl[5]  = '{1'b0, 3'b111, A123, D123, 3'b010, 1'b1, 5'd1, 32'hA1, 32'h2, 16'd2};
        tbl[6]  = '{1'b0, 3'b111, A123, D123, 3'b100, 1'b1, 5'd2, 32'hA2, 32'h4, 16'd3};
        tbl[7]  = '{1'b1, 3'b111, A123, D123, 3'b000, 1'b1, 5'd3, 32'hA3, 32'h8, 16'd4};
        tbl[8]  = '{1'b0, 3'b010, {5'd0, 5'd2, 5'd0}, {32'd0, 32'hB2, 32'd0},
                    3'b010, 1'b0, 5'd3, 32'hA3, 32'h0, 16'd5};
        tbl[9]  = '{1'b0, 3'b100, 15'd0, {32'hFFFFFFFF, 64'd0}, 3'b100, 1'b1, 5'd2, 32'hB2, 32'h4, 16'd5};
        tbl[10] = '{1'b0, 3'b000, 15'd0, 96'd0, 3'b000, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0, 16'd6};
        tbl[11] = '{1'b0, 3'b000, 15'd0, 96'd0, 3'b000, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0, 16'd6};

        // Reset state, with a request present to show ready is forced low
        nrst = 1'b0; hold = 1'b0;
        req_valid = 3'b111; req_addr = A123; req_data = D123;
        #3;
        chk("reset_ready", {29'd0, req_ready}, 32'h0);
        chk("reset_en", {31'd0, rf_wr_en}, 32'h0);
        chk("reset_pending", pending, 32'h0);
        chk("reset_count", {16'd0, wr_count}, 32'h0);
        chk("reset_addr", {27'd0, rf_wr_addr}, 32'h0);
        chk("reset_data", rf_wrdata, 32'h0);

        // Vector table
        do_reset();
        for (int i = 0; i < 12; i++) begin
            hold      = tbl[i].hold;
            req_valid = tbl[i].v;
            req_addr  = tbl[i].a;
            req_data  = tbl[i].d;
            #1;
            chk($sformatf("v%0d_ready", i), {29'd0, req_ready}, {29'd0, tbl[i].ready});
            chk($sformatf("v%0d_en", i), {31'd0, rf_wr_en}, {31'd0, tbl[i].en});
            chk($sformatf("v%0d_addr", i), {27'd0, rf_wr_addr}, {27'd0, tbl[i].waddr});
            chk($sformatf("v%0d_data", i), rf_wrdata, tbl[i].wdata);
            chk($sformatf("v%0d_pend", i), pending, tbl[i].pend);
            chk($sformatf("v%0d_cnt", i), {16'd0, wr_count}, {16'd0, tbl[i].cnt});
            step();
        end

        // Round-robin from reset: grants 0,1,2,0,1,2, writes follow a cycle later
        do_reset();
        req_valid = 3'b111; req_addr = A123; req_data = D123;
        for (int c = 0; c < 7; c++) begin
            #1;
            if (c < 6) chk($sformatf("rr_grant%0d", c), {29'd0, req_ready}, 32'd1 << (c % 3));
            if (c > 0) chk($sformatf("rr_waddr%0d", c), {27'd0, rf_wr_addr}, ((c - 1) % 3) + 1);
            step();
        end
        req_valid = '0;

        // Same-address conflict: source 0 then source 2, last granted wins
        do_reset();
        req_valid = 3'b101; req_addr = {5'd9, 5'd0, 5'd9}; req_data = {32'h22, 32'h0, 32'h11};
        #1 chk("conf_first", {29'd0, req_ready}, 32'b001);
        step();
        req_valid = 3'b100;
        #1 chk("conf_second", {29'd0, req_ready}, 32'b100);
        chk("conf_wr1", rf_wrdata, 32'h11);
        step();
        req_valid = '0;
        step(); step();
        chk("conf_reg9", rf_model[9], 32'h22);

        // Hold: 4 stalled cycles, pointer frozen so source 1 wins on release
        do_reset();
        req_valid = 3'b001; req_addr = {5'd0, 5'd0, 5'd4}; req_data = {64'd0, 32'h44};
        #1 chk("hold_pre", {29'd0, req_ready}, 32'b001);
        step();
        hold = 1'b1; req_valid = 3'b011; req_addr = {5'd0, 5'd6, 5'd4};
        for (int c = 0; c < 4; c++) begin
            #1 chk($sformatf("hold_ready%0d", c), {29'd0, req_ready}, 32'h0);
            if (c > 0) chk($sformatf("hold_en%0d", c), {31'd0, rf_wr_en}, 32'h0);
            step();
        end
        hold = 1'b0;
        #1 chk("hold_release", {29'd0, req_ready}, 32'b010);
        step();
        req_valid = '0;
        #1 chk("hold_wr", {27'd0, rf_wr_addr}, 32'd6);

        // Asynchronous reset mid-write
        do_reset();
        req_valid = 3'b001; req_addr = {10'd0, 5'd3}; req_data = {64'd0, 32'h33};
        step();
        req_addr = {10'd0, 5'd5}; req_data = {64'd0, 32'h55};
        step();
        req_valid = '0;
        #1 chk("mid_en_before", {31'd0, rf_wr_en}, 32'h1);
        chk("mid_addr_before", {27'd0, rf_wr_addr}, 32'd5);
        chk("mid_cnt_before", {16'd0, wr_count}, 32'd1);
        nrst = 1'b0;
        #1 chk("mid_en", {31'd0, rf_wr_en}, 32'h0);
        chk("mid_pending", pending, 32'h0);
        chk("mid_cnt", {16'd0, wr_count}, 32'h0);
        step();
        nrst = 1'b1;
        req_valid = 3'b111; req_addr = A123; req_data = D123;
        #1 chk("mid_first_grant", {29'd0, req_ready}, 32'b001);
        step();
        req_valid = '0;

        // wr_count wrap
        do_reset();
        req_valid = 3'b001; req_addr = {10'd0, 5'd1}; req_data = {64'd0, 32'h1};
        repeat (65535) @(posedge clk);
        #1 req_valid = '0;
        step(); step(); step();
        chk("wrap_ffff", {16'd0, wr_count}, 32'hFFFF);
        req_valid = 3'b001;
        step();
        req_valid = '0;
        step(); step();
        chk("wrap_zero", {16'd0, wr_count}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
